// File: rtl/counter_seq_ctrl.sv
// counter_seq_ctrl: drives the load / cnt_en / oe pins of the 8-bit tile counter.
// A single start command loads a start value, then issues run_len increments
// spaced prescale+1 cycles apart. After that, oe is raised for show_len cycles
// and a one-cycle done pulse is issued. A shadow copy of the value the counter
// should hold is kept in exp_cnt for external checking.
// Every output is decoded from registered state, so no input reaches an output
// through combinational logic.

module counter_seq_ctrl #(
  parameter int W    = 8,
  parameter int PS_W = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            i_ena,
  input  logic            i_start,
  input  logic            i_abort,
  input  logic [W-1:0]    i_start_val,
  input  logic [W-1:0]    i_run_len,
  input  logic [PS_W-1:0] i_prescale,
  input  logic [W-1:0]    i_show_len,
  output logic            o_load,
  output logic [W-1:0]    o_load_val,
  output logic            o_cnt_en,
  output logic            o_oe,
  output logic            o_busy,
  output logic            o_done,
  output logic [W-1:0]    o_exp_cnt
);

  // Sequencer states; the encoding is kept stable for legacy tooling.
  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_LOAD  = 3'd1;
  localparam logic [2:0] ST_COUNT = 3'd2;
  localparam logic [2:0] ST_SHOW  = 3'd3;
  localparam logic [2:0] ST_DONE  = 3'd4;

  localparam logic [W-1:0]    W_ZERO  = {W{1'b0}};
  localparam logic [W-1:0]    W_ONE   = {{(W-1){1'b0}}, 1'b1};
  localparam logic [PS_W-1:0] PS_ZERO = {PS_W{1'b0}};
  localparam logic [PS_W-1:0] PS_ONE  = {{(PS_W-1){1'b0}}, 1'b1};

  // Registered state.
  logic [2:0]      r_state;
  logic [W-1:0]    r_load_val;  // latched start value
  logic [W-1:0]    r_rem;       // increments still to issue
  logic [PS_W-1:0] r_ps_q;      // latched prescale
  logic [W-1:0]    r_shw;       // oe cycles still to issue
  logic [PS_W-1:0] r_pre;       // prescale phase within the COUNT state
  logic [W-1:0]    r_exp_cnt;   // shadow of the counter value

  // Next-state values.
  logic [2:0]      w_state_nxt;
  logic [W-1:0]    w_load_val_nxt;
  logic [W-1:0]    w_rem_nxt;
  logic [PS_W-1:0] w_ps_q_nxt;
  logic [W-1:0]    w_shw_nxt;
  logic [PS_W-1:0] w_pre_nxt;
  logic [W-1:0]    w_exp_cnt_nxt;

  // One increment fires at the last phase of each prescale period.
  logic w_fire;
  assign w_fire = (r_state == ST_COUNT) && (r_pre == r_ps_q);

  // Next-state and datapath decode. Abort overrides all other updates, so the
  // shadow count keeps the value it held when the abort was sampled.
  always_comb begin
    w_state_nxt    = r_state;
    w_load_val_nxt = r_load_val;
    w_rem_nxt      = r_rem;
    w_ps_q_nxt     = r_ps_q;
    w_shw_nxt      = r_shw;
    w_pre_nxt      = r_pre;
    w_exp_cnt_nxt  = r_exp_cnt;
    case (r_state)
      ST_IDLE: begin
        if (i_start && !i_abort) begin
          w_load_val_nxt = i_start_val;
          w_rem_nxt      = i_run_len;
          w_ps_q_nxt     = i_prescale;
          w_shw_nxt      = i_show_len;
          w_state_nxt    = ST_LOAD;
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_LOAD: begin
        if (i_abort) begin
          w_state_nxt = ST_IDLE;
        end else begin
          w_exp_cnt_nxt = r_load_val;
          w_pre_nxt     = PS_ZERO;
          if (r_rem != W_ZERO) begin
            w_state_nxt = ST_COUNT;
          end else if (r_shw != W_ZERO) begin
            w_state_nxt = ST_SHOW;
          end else begin
            w_state_nxt = ST_DONE;
          end
        end
      end
      ST_COUNT: begin
        if (i_abort) begin
          w_state_nxt = ST_IDLE;
        end else if (w_fire) begin
          w_pre_nxt     = PS_ZERO;
          w_rem_nxt     = r_rem - W_ONE;
          w_exp_cnt_nxt = r_exp_cnt + W_ONE;  // wraps modulo 2^W
          if (r_rem == W_ONE) begin
            if (r_shw != W_ZERO) begin
              w_state_nxt = ST_SHOW;
            end else begin
              w_state_nxt = ST_DONE;
            end
          end else begin
            w_state_nxt = ST_COUNT;
          end
        end else begin
          w_pre_nxt = r_pre + PS_ONE;
        end
      end
      ST_SHOW: begin
        if (i_abort) begin
          w_state_nxt = ST_IDLE;
        end else begin
          w_shw_nxt = r_shw - W_ONE;
          if (r_shw == W_ONE) begin
            w_state_nxt = ST_DONE;
          end else begin
            w_state_nxt = ST_SHOW;
          end
        end
      end
      ST_DONE: begin
        w_state_nxt = ST_IDLE;
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  // State and datapath registers; ena=0 freezes everything.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= ST_IDLE;
      r_load_val <= W_ZERO;
      r_rem      <= W_ZERO;
      r_ps_q     <= PS_ZERO;
      r_shw      <= W_ZERO;
      r_pre      <= PS_ZERO;
      r_exp_cnt  <= W_ZERO;
    end else if (i_ena) begin
      r_state    <= w_state_nxt;
      r_load_val <= w_load_val_nxt;
      r_rem      <= w_rem_nxt;
      r_ps_q     <= w_ps_q_nxt;
      r_shw      <= w_shw_nxt;
      r_pre      <= w_pre_nxt;
      r_exp_cnt  <= w_exp_cnt_nxt;
    end
  end

  // Output pins are pure decodes of registered state.
  assign o_load     = (r_state == ST_LOAD);
  assign o_cnt_en   = w_fire;
  assign o_oe       = (r_state == ST_SHOW);
  assign o_done     = (r_state == ST_DONE);
  assign o_busy     = (r_state != ST_IDLE);
  assign o_load_val = r_load_val;
  assign o_exp_cnt  = r_exp_cnt;

endmodule

// File: tb/tb_counter_seq_ctrl.sv
// Bench for counter_seq_ctrl. A timeline model expands every accepted command
// into a per-cycle queue of expected pin activity, and a compare process checks
// all DUT outputs against that queue on every clock. The directed tests below
// add literal expectations at hand-computed cycles.

module tb_counter_seq_ctrl;

  logic       clk       = 1'b0;
  logic       rst_n     = 1'b0;
  logic       ena       = 1'b1;
  logic       start     = 1'b0;
  logic       abort     = 1'b0;
  logic [7:0] start_val = 8'h00;
  logic [7:0] run_len   = 8'h00;
  logic [3:0] prescale  = 4'h0;
  logic [7:0] show_len  = 8'h00;

  logic       load, cnt_en, oe, busy, done;
  logic [7:0] load_val, exp_cnt;

  int checks = 0;
  int errors = 0;

  counter_seq_ctrl #(.W(8), .PS_W(4)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_ena      (ena),
    .i_start    (start),
    .i_abort    (abort),
    .i_start_val(start_val),
    .i_run_len  (run_len),
    .i_prescale (prescale),
    .i_show_len (show_len),
    .o_load     (load),
    .o_load_val (load_val),
    .o_cnt_en   (cnt_en),
    .o_oe       (oe),
    .o_busy     (busy),
    .o_done     (done),
    .o_exp_cnt  (exp_cnt)
  );

  // Free-running clock with a 10-unit period.
  always #5 clk = ~clk;

  task automatic chk1(input string name, input logic got, input logic exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0b exp=%0b t=%0t", name, got, exp, $time);
    end
  endtask

  task automatic chk8(input string name, input logic [7:0] got, input logic [7:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%02h exp=%02h t=%0t", name, got, exp, $time);
    end
  endtask

  // Timeline model: each entry is the pin activity of one ena=1 cycle.
  typedef struct packed {
    logic ld;
    logic ce;
    logic oe;
    logic dn;
  } ent_t;

  ent_t       q[$];
  ent_t       hd;
  logic [7:0] m_exp = 8'h00;
  logic [7:0] m_ld  = 8'h00;

  // Advance the model at each edge and compare the DUT one time unit later.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q.delete();
      m_exp = 8'h00;
      m_ld  = 8'h00;
    end else if (ena) begin
      if (q.size() != 0) begin
        if (abort) begin
          q.delete();
        end else begin
          hd = q.pop_front();
          if (hd.ld) m_exp = m_ld;
          if (hd.ce) m_exp = m_exp + 8'd1;
        end
      end else if (start && !abort) begin
        m_ld = start_val;
        q.push_back(ent_t'(4'b1000));
        for (int i = 0; i < int'(run_len); i++) begin
          for (int j = 0; j < int'(prescale); j++) q.push_back(ent_t'(4'b0000));
          q.push_back(ent_t'(4'b0100));
        end
        for (int k = 0; k < int'(show_len); k++) q.push_back(ent_t'(4'b0010));
        q.push_back(ent_t'(4'b0001));
      end
    end
    #1;
    hd = (q.size() != 0) ? q[0] : ent_t'(4'b0000);
    chk1("m_load",     load,     hd.ld);
    chk1("m_cnt_en",   cnt_en,   hd.ce);
    chk1("m_oe",       oe,       hd.oe);
    chk1("m_done",     done,     hd.dn);
    chk1("m_busy",     busy,     q.size() != 0);
    chk8("m_exp_cnt",  exp_cnt,  m_exp);
    chk8("m_load_val", load_val, m_ld);
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Issue one start command; returns at the negedge inside cycle t+1.
  task automatic cmd(input logic [7:0] sv, input logic [7:0] rl,
                     input logic [3:0] ps, input logic [7:0] sl);
    start_val = sv;
    run_len   = rl;
    prescale  = ps;
    show_len  = sl;
    start     = 1'b1;
    @(negedge clk);
    start     = 1'b0;
  endtask

  initial begin
    // Reset values.
    tick(2);
    chk1("rst_busy", busy, 1'b0);
    chk1("rst_load", load, 1'b0);
    chk8("rst_exp", exp_cnt, 8'h00);
    chk8("rst_load_val", load_val, 8'h00);
    rst_n = 1'b1;
    tick(2);

    // 1: basic run with show window.
    cmd(8'hF0, 8'd3, 4'd0, 8'd2);
    chk1("t1_load", load, 1'b1);
    tick(1); chk1("t1_cnt_first", cnt_en, 1'b1);
    tick(2); chk1("t1_cnt_last", cnt_en, 1'b1);
    tick(1); chk1("t1_oe_first", oe, 1'b1);
    tick(2); chk1("t1_done", done, 1'b1);
    chk8("t1_exp", exp_cnt, 8'hF3);
    tick(1); chk1("t1_idle", busy, 1'b0);

    // 2: wrap through 0xFF, no show window, inputs changed after latch.
    cmd(8'hFE, 8'd4, 4'd0, 8'd0);
    start_val = 8'hAA;
    tick(5); chk1("t2_done", done, 1'b1);
    chk8("t2_exp", exp_cnt, 8'h02);
    chk8("t2_load_val", load_val, 8'hFE);
    tick(1);

    // 3: prescale 2.
    cmd(8'h10, 8'd2, 4'd2, 8'd0);
    tick(2); chk1("t3_no_cnt_t3", cnt_en, 1'b0);
    tick(1); chk1("t3_cnt_t4", cnt_en, 1'b1);
    tick(3); chk1("t3_cnt_t7", cnt_en, 1'b1);
    tick(1); chk1("t3_done", done, 1'b1);
    chk8("t3_exp", exp_cnt, 8'h12);
    tick(1);

    // 4: empty command.
    cmd(8'h33, 8'd0, 4'd0, 8'd0);
    chk1("t4_load", load, 1'b1);
    tick(1); chk1("t4_done", done, 1'b1);
    chk8("t4_exp", exp_cnt, 8'h33);
    tick(1);

    // 5a: start with abort in IDLE is refused; abort mid-COUNT; start while busy.
    start = 1'b1; abort = 1'b1;
    tick(1); start = 1'b0; abort = 1'b0;
    chk1("t5_abort_wins", busy, 1'b0);
    cmd(8'h40, 8'd5, 4'd1, 8'd3);
    tick(1); start_val = 8'h99; start = 1'b1;
    tick(1); start = 1'b0;
    chk1("t5_cnt_t3", cnt_en, 1'b1);
    tick(1); abort = 1'b1;
    tick(1); abort = 1'b0;
    chk1("t5_idle", busy, 1'b0);
    chk1("t5_no_done", done, 1'b0);
    chk8("t5_exp", exp_cnt, 8'h41);
    chk8("t5_load_val", load_val, 8'h40);
    tick(2);

    // 5b: ena low for three edges mid-COUNT shifts the timeline by three.
    cmd(8'h20, 8'd3, 4'd0, 8'd1);
    tick(1); ena = 1'b0;
    tick(3); ena = 1'b1;
    chk1("t5b_frozen_cnt", cnt_en, 1'b1);
    chk8("t5b_frozen_exp", exp_cnt, 8'h20);
    tick(1); chk8("t5b_exp_t6", exp_cnt, 8'h21);
    tick(3); chk1("t5b_done", done, 1'b1);
    chk8("t5b_exp", exp_cnt, 8'h23);
    tick(1);

    // 6: async reset mid-SHOW, then a normal run.
    cmd(8'h55, 8'd1, 4'd0, 8'd4);
    tick(3); chk1("t6_oe", oe, 1'b1);
    #2 rst_n = 1'b0;
    #1;
    chk1("t6_rst_oe", oe, 1'b0);
    chk1("t6_rst_busy", busy, 1'b0);
    chk1("t6_rst_done", done, 1'b0);
    chk8("t6_rst_exp", exp_cnt, 8'h00);
    @(negedge clk); rst_n = 1'b1;
    tick(1);
    cmd(8'hF0, 8'd3, 4'd0, 8'd2);
    tick(6); chk1("t6_done", done, 1'b1);
    chk8("t6_exp", exp_cnt, 8'hF3);
    tick(2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
